// File: rtl/mmc1_serial_writer.sv
// MMC1 CPU-bus write sequencer: buffers parallel register loads in a FIFO and
// replays each one as the mapper's five-write serial protocol (or a single reset write).
`default_nettype none

module mmc1_serial_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic       M2,
  input  logic       nRES,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_RESET,
  input  logic [1:0] REQ_REG,
  input  logic [4:0] REQ_DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       nROMSEL,
  output logic       CPU_RnW,
  output logic       CPU_A14,
  output logic       CPU_A13,
  output logic       CPU_D0,
  output logic       CPU_D7
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

  generate
    if (GAP_CYCLES < 1) begin : g_gap_check
      $error("mmc1_serial_writer: GAP_CYCLES must be at least 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("mmc1_serial_writer: FIFO_DEPTH must be a power of two, at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, GAP = 2'd2} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];  // {reset, reg[1:0], data[4:0]}
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          push, pop;
  logic [7:0]    head;
  logic          cur_reset;
  logic [4:0]    cur_data;
  logic [2:0]    bitcnt;
  logic [GW-1:0] gap_cnt;
  logic          leave_gap, finish, busy_next;

  assign push = REQ_VALID & REQ_READY;
  assign pop  = (state == IDLE) && (count != '0);
  assign head = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  assign leave_gap = (state == GAP) && (gap_cnt == GAP_LAST);
  assign finish    = leave_gap && (cur_reset || bitcnt == 3'd4);
  assign busy_next = (count_next != '0) || pop || (state == WRITE) ||
                     (state == GAP && !finish);

  always_ff @(posedge M2) begin
    if (push) mem[wr_ptr] <= {REQ_RESET, REQ_REG, REQ_DATA};
  end

  // Ready comes from the registered count, so a full FIFO refuses even while popping.
  always_ff @(posedge M2 or negedge nRES) begin
    if (!nRES) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      REQ_READY <= 1'b1;
      BUSY      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      REQ_READY <= (count_next != FULL_COUNT);
      BUSY      <= busy_next;
    end
  end

  always_ff @(posedge M2 or negedge nRES) begin
    if (!nRES) begin
      state     <= IDLE;
      cur_reset <= 1'b0;
      cur_data  <= '0;
      bitcnt    <= '0;
      gap_cnt   <= '0;
      DONE      <= 1'b0;
      nROMSEL   <= 1'b1;
      CPU_RnW   <= 1'b1;
      CPU_A14   <= 1'b0;
      CPU_A13   <= 1'b0;
      CPU_D0    <= 1'b0;
      CPU_D7    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            cur_reset <= head[7];
            cur_data  <= head[4:0];
            bitcnt    <= '0;
            state     <= WRITE;
            nROMSEL   <= 1'b0;
            CPU_RnW   <= 1'b0;
            CPU_A14   <= head[6];
            CPU_A13   <= head[5];
            CPU_D7    <= head[7];
            CPU_D0    <= head[7] ? 1'b0 : head[0];
          end
        end
        WRITE: begin
          state   <= GAP;
          nROMSEL <= 1'b1;
          CPU_RnW <= 1'b1;
          gap_cnt <= '0;
          DONE    <= cur_reset || (bitcnt == 3'd4);
        end
        GAP: begin
          if (!leave_gap) begin
            gap_cnt <= gap_cnt + GW'(1);
          end else if (finish) begin
            bitcnt <= '0;
            state  <= IDLE;
            // Bus lines only park at zero when nothing else is queued.
            if (count_next == '0) begin
              CPU_A14 <= 1'b0;
              CPU_A13 <= 1'b0;
              CPU_D0  <= 1'b0;
              CPU_D7  <= 1'b0;
            end
          end else begin
            bitcnt  <= bitcnt + 3'd1;
            state   <= WRITE;
            nROMSEL <= 1'b0;
            CPU_RnW <= 1'b0;
            CPU_D0  <= cur_data[bitcnt + 3'd1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
